// File: rtl/full_adder_if.sv
// full_adder_if: bundles the data-side signals of the full_adder leaf cell.
//
// Signals:
//   a, b, c    addend bits and carry-in (driven by the master)
//   sum, carry combinational result (driven by the adder)
//   sum_q      registered sum, one clk after the inputs
//   carry_q    registered carry, one clk after the inputs
//   carry_cnt  saturating count of carry=1 cycles, CNT_W bits wide
//              (exists only when FULL_ADDER_CARRY_CNT_EN is defined)
//
// Modports:
//   master  drives a/b/c and observes every result
//   slave   the adder side: takes a/b/c and drives every result
//
// Optional feature macro: FULL_ADDER_CARRY_CNT_EN
interface full_adder_if #(
  parameter int CNT_W = 8
);

  // The counter width can still be set with the feature compiled out, so
  // it is range-checked in every build.
  if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
    $error("full_adder_if: CNT_W must lie in 2..32");
  end

  logic a;
  logic b;
  logic c;
  logic sum;
  logic carry;
  logic sum_q;
  logic carry_q;
`ifdef FULL_ADDER_CARRY_CNT_EN
  logic [CNT_W-1:0] carry_cnt;

  modport master (
    output a, b, c,
    input  sum, carry, sum_q, carry_q, carry_cnt
  );

  modport slave (
    input  a, b, c,
    output sum, carry, sum_q, carry_q, carry_cnt
  );
`else
  modport master (
    output a, b, c,
    input  sum, carry, sum_q, carry_q
  );

  modport slave (
    input  a, b, c,
    output sum, carry, sum_q, carry_q
  );
`endif

endinterface

// File: rtl/full_adder.sv
// full_adder: single-bit full adder used as the leaf cell of ripple and
// carry-save adders, with a clocked shadow copy of the result.
//
// Ports:
//   clk  rising-edge clock for the registered stage
//   rst  synchronous, active-high reset (registered outputs only)
//   bus  full_adder_if.slave
//          a, b, c    inputs
//          sum        a ^ b ^ c, purely combinational
//          carry      majority(a, b, c), purely combinational
//          sum_q      sum registered on clk
//          carry_q    carry registered on clk
//          carry_cnt  saturating count of carry=1 cycles (optional)
//
// Parameters:
//   RESET_VAL  value loaded into sum_q and carry_q on reset (bit 0 only)
//   CNT_W      width of the optional carry event counter, 2..32
//
// Optional feature macro: FULL_ADDER_CARRY_CNT_EN
//   Defined:     carry_cnt exists and counts cycles with carry=1,
//                saturating at all-ones and clearing on reset.
//   Not defined: carry_cnt and its counter are absent.
module full_adder #(
  parameter int RESET_VAL = 0,
  parameter int CNT_W     = 8
) (
  input logic         clk,
  input logic         rst,
  full_adder_if.slave bus
);

  localparam logic RST_BIT = RESET_VAL[0];

  if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
    $error("full_adder: CNT_W must lie in 2..32");
  end

  logic sum_c;
  logic carry_c;
  logic sum_r;
  logic carry_r;

  // The combinational path must work with the clock idle, so it depends on
  // nothing but a/b/c. Plain operators keep X/Z on an input visible as X.
  always_comb begin
    sum_c   = bus.a ^ bus.b ^ bus.c;
    carry_c = (bus.a & bus.b) | (bus.a & bus.c) | (bus.b & bus.c);
  end

  assign bus.sum   = sum_c;
  assign bus.carry = carry_c;

  // Shadow registers: reset touches only these, never sum/carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r   <= RST_BIT;
      carry_r <= RST_BIT;
    end else begin
      sum_r   <= sum_c;
      carry_r <= carry_c;
    end
  end

  assign bus.sum_q   = sum_r;
  assign bus.carry_q = carry_r;

`ifdef FULL_ADDER_CARRY_CNT_EN
  logic [CNT_W-1:0] cnt_r;

  // Counts cycles with carry=1 and sticks at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (carry_c && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign bus.carry_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed self-checking bench for full_adder.
// Runs the idle-clock truth-table sweep, then reset, pipeline latency and
// reset-override sequences, plus the carry counter sequence when
// FULL_ADDER_CARRY_CNT_EN is defined (built with CNT_W=2).
module tb_full_adder;

  localparam int CNT_W = 2;

  logic clk;
  logic rst;
  logic run_clk;

  int total;
  int bad;

  full_adder_if #(.CNT_W(CNT_W)) fa_if ();

  full_adder #(
    .RESET_VAL(0),
    .CNT_W    (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(fa_if)
  );

  // The clock only toggles once run_clk is raised, so the combinational
  // sweep sees a clock held at 0.
  initial clk = 1'b0;
  always #5 if (run_clk) clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [2:0] abc);
    fa_if.a = abc[2];
    fa_if.b = abc[1];
    fa_if.c = abc[0];
  endtask

  // Hand-computed {carry,sum} for abc = 000 .. 111.
  logic [1:0] exp_tbl [8];

  initial begin
    total   = 0;
    bad     = 0;
    run_clk = 1'b0;
    rst     = 1'b0;
    exp_tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    apply_stimulus(3'b000);

    // Combinational sweep, clock idle and reset never asserted.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(3'(i));
      #10;
      check_output($sformatf("sweep_abc%0d", i),
                   {30'd0, fa_if.carry, fa_if.sum}, {30'd0, exp_tbl[i]});
    end

    run_clk = 1'b1;

    // Reset held for two edges with abc=111.
    @(negedge clk);
    apply_stimulus(3'b111);
    rst = 1'b1;
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); #1;
      check_output($sformatf("rst_q_edge%0d", e),
                   {30'd0, fa_if.carry_q, fa_if.sum_q}, 32'd0);
      check_output($sformatf("rst_comb_edge%0d", e),
                   {30'd0, fa_if.carry, fa_if.sum}, 32'd3);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_output("rst_release_q", {30'd0, fa_if.carry_q, fa_if.sum_q}, 32'd3);

    // Pipeline latency: 001 -> 011 -> 000.
    @(negedge clk);
    apply_stimulus(3'b001);
    @(posedge clk); #1;
    check_output("lat_001", {30'd0, fa_if.carry_q, fa_if.sum_q}, 32'd1);
    @(negedge clk);
    apply_stimulus(3'b011);
    #1;
    check_output("lat_hold_before_edge", {30'd0, fa_if.carry_q, fa_if.sum_q}, 32'd1);
    @(posedge clk); #1;
    check_output("lat_011", {30'd0, fa_if.carry_q, fa_if.sum_q}, 32'd2);
    @(negedge clk);
    apply_stimulus(3'b000);
    @(posedge clk); #1;
    check_output("lat_000", {30'd0, fa_if.carry_q, fa_if.sum_q}, 32'd0);

    // Reset override with abc=110 (data would load carry=1).
    @(negedge clk);
    apply_stimulus(3'b110);
    rst = 1'b1;
    @(posedge clk); #1;
    check_output("ovr_carry_q", {31'd0, fa_if.carry_q}, 32'd0);
    check_output("ovr_sum_q", {31'd0, fa_if.sum_q}, 32'd0);
    check_output("ovr_comb", {30'd0, fa_if.carry, fa_if.sum}, 32'd2);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_output("ovr_resume", {30'd0, fa_if.carry_q, fa_if.sum_q}, 32'd2);

`ifdef FULL_ADDER_CARRY_CNT_EN
    // Counter: reset, then abc=011 for 5 edges -> 1,2,3,3,3.
    @(negedge clk);
    apply_stimulus(3'b011);
    rst = 1'b1;
    @(posedge clk); #1;
    check_output("cnt_after_rst", 32'(fa_if.carry_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk); #1;
      check_output($sformatf("cnt_edge%0d", e), 32'(fa_if.carry_cnt),
                   (e < 3) ? 32'(e + 1) : 32'd3);
    end
    @(negedge clk);
    apply_stimulus(3'b001);
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); #1;
      check_output($sformatf("cnt_hold%0d", e), 32'(fa_if.carry_cnt), 32'd3);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_output("cnt_clear", 32'(fa_if.carry_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
